// File: rtl/dmi_rsp_engine.sv
// ---------------------------------------------------------------------------
// dmi_rsp_engine
//   DMI responder on the debug-module side of the DMI link. It takes request
//   packets coming out of the request-direction CDC, performs the register
//   access on the debug-module register bus, and hands a response packet to
//   the response-direction CDC over a valid/ready port. Only one transaction
//   is in flight at a time, and a bus timeout guards against a silent target.
//
// Parameters
//   ABITS    DMI address width
//   TIMEOUT  max cycles spent waiting for reg_ack_i (0 = wait forever)
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   req_vld_i/rdy  request handshake; payload {addr, data[31:0], op[1:0]}
//                  op 0=nop 1=read 2=write 3=reserved
//   rsp_vld_o/rdy  response handshake; payload {data[31:0], resp[1:0]}
//                  resp 0=success 2=failed
//   reg_req_o      register access request, held until ack or timeout
//   reg_we_o       1=write 0=read
//   reg_addr_o     register address
//   reg_wdata_o    write data
//   reg_ack_i      single-cycle completion pulse
//   reg_rdata_i    read data, sampled with reg_ack_i
//   reg_err_i      access error, sampled with reg_ack_i
// ---------------------------------------------------------------------------
module dmi_rsp_engine #(
  parameter int ABITS   = 7,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_vld_i,
  input  logic [ABITS+33:0] req_pld_i,
  output logic             req_rdy_o,
  output logic             rsp_vld_o,
  output logic [33:0]      rsp_pld_o,
  input  logic             rsp_rdy_i,
  output logic             reg_req_o,
  output logic             reg_we_o,
  output logic [ABITS-1:0] reg_addr_o,
  output logic [31:0]      reg_wdata_o,
  input  logic             reg_ack_i,
  input  logic [31:0]      reg_rdata_i,
  input  logic             reg_err_i
);

  // Counter keeps at least one bit so a TIMEOUT of 0 still elaborates cleanly.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CW-1:0] CNT_LAST = TO_EN ? CW'(TIMEOUT - 1) : '0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  localparam logic [1:0] RESP_OK   = 2'd0;
  localparam logic [1:0] RESP_FAIL = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [ABITS-1:0] addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [33:0]      rsp_pld_q, rsp_pld_d;

  logic [ABITS-1:0] req_addr;
  logic [31:0]      req_data;
  logic [1:0]       req_op;
  logic             req_fire;

  assign req_addr = req_pld_i[ABITS+33:34];
  assign req_data = req_pld_i[33:2];
  assign req_op   = req_pld_i[1:0];

  // Ready is withheld while reset is asserted even though the state already
  // reads IDLE, so nothing can be accepted across the reset release edge.
  assign req_rdy_o = (state_q == ST_IDLE) && !rst;
  assign req_fire  = req_vld_i && req_rdy_o;

  assign rsp_vld_o   = (state_q == ST_RESP);
  assign rsp_pld_o   = rsp_pld_q;
  assign reg_req_o   = (state_q == ST_ACCESS);
  assign reg_we_o    = we_q;
  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;

  // Next-state logic. The response payload is captured once on entry to
  // RESP and then held untouched until the response handshake completes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rsp_pld_d = rsp_pld_q;

    case (state_q)
      ST_IDLE: begin
        if (req_fire) begin
          if (req_op == OP_READ || req_op == OP_WRITE) begin
            addr_d  = req_addr;
            wdata_d = req_data;
            we_d    = (req_op == OP_WRITE);
            cnt_d   = '0;
            state_d = ST_ACCESS;
          end else if (req_op == OP_NOP) begin
            rsp_pld_d = {32'h0, RESP_OK};
            state_d   = ST_RESP;
          end else begin
            rsp_pld_d = {32'h0, RESP_FAIL};
            state_d   = ST_RESP;
          end
        end
      end

      ST_ACCESS: begin
        // Saturating count; an ack on the final timeout cycle still wins.
        if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (reg_ack_i) begin
          rsp_pld_d = {(we_q ? 32'h0 : reg_rdata_i), (reg_err_i ? RESP_FAIL : RESP_OK)};
          state_d   = ST_RESP;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          rsp_pld_d = {32'h0, RESP_FAIL};
          state_d   = ST_RESP;
        end
      end

      ST_RESP: begin
        if (rsp_rdy_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_pld_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rsp_pld_q <= rsp_pld_d;
    end
  end

endmodule

// File: tb/tb_dmi_rsp_engine.sv
// ---------------------------------------------------------------------------
// tb_dmi_rsp_engine
//   Self-checking bench for dmi_rsp_engine (ABITS=7, TIMEOUT=4). Expected
//   responses, access lengths and handshake behaviour come from a
//   transaction-level model of the DMI responder rules.
// ---------------------------------------------------------------------------
module tb_dmi_rsp_engine;

  localparam int ABITS   = 7;
  localparam int TIMEOUT = 4;
  localparam int NO_ACK  = 100;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_vld_i;
  logic [ABITS+33:0] req_pld_i;
  logic             req_rdy_o;
  logic             rsp_vld_o;
  logic [33:0]      rsp_pld_o;
  logic             rsp_rdy_i;
  logic             reg_req_o;
  logic             reg_we_o;
  logic [ABITS-1:0] reg_addr_o;
  logic [31:0]      reg_wdata_o;
  logic             reg_ack_i;
  logic [31:0]      reg_rdata_i;
  logic             reg_err_i;

  int nChecks = 0;
  int nFails  = 0;

  dmi_rsp_engine #(.ABITS(ABITS), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_vld_i   (req_vld_i),
    .req_pld_i   (req_pld_i),
    .req_rdy_o   (req_rdy_o),
    .rsp_vld_o   (rsp_vld_o),
    .rsp_pld_o   (rsp_pld_o),
    .rsp_rdy_i   (rsp_rdy_i),
    .reg_req_o   (reg_req_o),
    .reg_we_o    (reg_we_o),
    .reg_addr_o  (reg_addr_o),
    .reg_wdata_o (reg_wdata_o),
    .reg_ack_i   (reg_ack_i),
    .reg_rdata_i (reg_rdata_i),
    .reg_err_i   (reg_err_i)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge, half a cycle
  // away from the rising edge the design acts on.
  task automatic run_txn(input logic [1:0] op, input logic [ABITS-1:0] addr,
                         input logic [31:0] wdata, input int ackAt,
                         input logic [31:0] rdata, input logic err,
                         input int hold, input string name);
    logic [33:0] expPld;
    int expCycles;
    int c;
    // Reference model: what a DMI responder must return for this request.
    if (op == 2'd0) begin
      expPld = 34'h0; expCycles = 0;
    end else if (op == 2'd3) begin
      expPld = {32'h0, 2'd2}; expCycles = 0;
    end else if (ackAt < TIMEOUT) begin
      expPld = {((op == 2'd1) ? rdata : 32'h0), (err ? 2'd2 : 2'd0)};
      expCycles = ackAt + 1;
    end else begin
      expPld = {32'h0, 2'd2}; expCycles = TIMEOUT;
    end

    @(negedge clk);
    nChecks++;
    if (req_rdy_o !== 1'b1) begin
      nFails++; $display("[TB] FAIL %s idle_ready: got %b want 1", name, req_rdy_o);
    end
    req_vld_i = 1'b1;
    req_pld_i = {addr, wdata, op};
    @(negedge clk);
    req_vld_i = 1'b0;
    req_pld_i = {$urandom, $urandom};

    c = 0;
    while (reg_req_o === 1'b1 && c < 20) begin
      nChecks++;
      if ({reg_we_o, reg_addr_o, reg_wdata_o, req_rdy_o, rsp_vld_o} !== {(op == 2'd2), addr, wdata, 1'b0, 1'b0}) begin
        nFails++;
        $display("[TB] FAIL %s access_hold: got we=%b addr=%h wdata=%h rdy=%b vld=%b want we=%b addr=%h wdata=%h rdy=0 vld=0",
                 name, reg_we_o, reg_addr_o, reg_wdata_o, req_rdy_o, rsp_vld_o, (op == 2'd2), addr, wdata);
      end
      reg_ack_i   = (c == ackAt);
      reg_rdata_i = (c == ackAt) ? rdata : $urandom;
      reg_err_i   = (c == ackAt) ? err : 1'($urandom);
      @(negedge clk);
      c++;
    end
    reg_ack_i = 1'b0;

    nChecks++;
    if (c != expCycles) begin
      nFails++; $display("[TB] FAIL %s req_cycles: got %0d want %0d", name, c, expCycles);
    end
    nChecks++;
    if ({rsp_vld_o, rsp_pld_o} !== {1'b1, expPld}) begin
      nFails++; $display("[TB] FAIL %s response: got vld=%b pld=%h want vld=1 pld=%h", name, rsp_vld_o, rsp_pld_o, expPld);
    end

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      nChecks++;
      if ({rsp_vld_o, rsp_pld_o, req_rdy_o, reg_req_o} !== {1'b1, expPld, 1'b0, 1'b0}) begin
        nFails++;
        $display("[TB] FAIL %s rsp_hold: got vld=%b pld=%h rdy=%b req=%b want vld=1 pld=%h rdy=0 req=0",
                 name, rsp_vld_o, rsp_pld_o, req_rdy_o, reg_req_o, expPld);
      end
    end

    rsp_rdy_i = 1'b1;
    @(negedge clk);
    rsp_rdy_i = 1'b0;
    nChecks++;
    if ({rsp_vld_o, req_rdy_o} !== 2'b01) begin
      nFails++; $display("[TB] FAIL %s after_handshake: got vld=%b rdy=%b want vld=0 rdy=1", name, rsp_vld_o, req_rdy_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    nChecks++;
    if ({req_rdy_o, rsp_vld_o, rsp_pld_o, reg_req_o, reg_we_o, reg_addr_o, reg_wdata_o} !== '0) begin
      nFails++;
      $display("[TB] FAIL reset_outputs: got rdy=%b vld=%b pld=%h req=%b we=%b addr=%h wdata=%h want all 0",
               req_rdy_o, rsp_vld_o, rsp_pld_o, reg_req_o, reg_we_o, reg_addr_o, reg_wdata_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    nChecks++;
    if (req_rdy_o !== 1'b1) begin
      nFails++; $display("[TB] FAIL reset_release_ready: got %b want 1", req_rdy_o);
    end
  endtask

  task automatic test_read();
    run_txn(2'd1, 7'h11, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0, "read_ack3");
  endtask

  task automatic test_write();
    run_txn(2'd2, 7'h10, 32'h1, 0, 32'hFFFF_FFFF, 1'b0, 0, "write_ack1");
  endtask

  task automatic test_nop_rsvd();
    run_txn(2'd0, 7'h22, 32'h1234_5678, NO_ACK, 32'h0, 1'b0, 0, "nop");
    run_txn(2'd3, 7'h33, 32'h8765_4321, NO_ACK, 32'h0, 1'b0, 0, "rsvd");
  endtask

  task automatic test_timeout();
    run_txn(2'd1, 7'h05, 32'h0, NO_ACK, 32'h0, 1'b0, 0, "timeout");
    run_txn(2'd1, 7'h06, 32'h0, TIMEOUT - 1, 32'hCAFE_F00D, 1'b0, 0, "ack_at_timeout");
  endtask

  task automatic test_err_backpressure();
    run_txn(2'd1, 7'h07, 32'h0, 1, 32'h0BAD_0BAD, 1'b1, 10, "read_err_hold");
  endtask

  // An ack pulse while idle must not start or complete anything.
  task automatic test_stray_ack();
    @(negedge clk);
    reg_ack_i = 1'b1; reg_rdata_i = 32'hA5A5_A5A5; reg_err_i = 1'b1;
    @(negedge clk);
    reg_ack_i = 1'b0;
    nChecks++;
    if ({rsp_vld_o, reg_req_o, req_rdy_o} !== 3'b001) begin
      nFails++; $display("[TB] FAIL stray_ack: got vld=%b req=%b rdy=%b want vld=0 req=0 rdy=1", rsp_vld_o, reg_req_o, req_rdy_o);
    end
    run_txn(2'd0, 7'h00, 32'h0, NO_ACK, 32'h0, 1'b0, 0, "nop_after_stray_ack");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      run_txn(2'($urandom_range(0, 3)), 7'($urandom), $urandom, $urandom_range(0, 5),
              $urandom, 1'($urandom), $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    req_vld_i = 1'b1;
    req_pld_i = {7'h2A, 32'h5555_AAAA, 2'd2};
    @(negedge clk);
    req_vld_i = 1'b0;
    nChecks++;
    if (reg_req_o !== 1'b1) begin
      nFails++; $display("[TB] FAIL midrst_access_started: got %b want 1", reg_req_o);
    end
    #2 rst = 1'b1;
    #1;
    nChecks++;
    if ({req_rdy_o, rsp_vld_o, rsp_pld_o, reg_req_o, reg_we_o, reg_addr_o, reg_wdata_o} !== '0) begin
      nFails++;
      $display("[TB] FAIL midrst_outputs: got rdy=%b vld=%b pld=%h req=%b we=%b addr=%h wdata=%h want all 0",
               req_rdy_o, rsp_vld_o, rsp_pld_o, reg_req_o, reg_we_o, reg_addr_o, reg_wdata_o);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) reg_ack_i = 1'b1; else reg_ack_i = 1'b0;
      nChecks++;
      if ({rsp_vld_o, reg_req_o, req_rdy_o} !== 3'b001) begin
        nFails++; $display("[TB] FAIL midrst_quiet: got vld=%b req=%b rdy=%b want vld=0 req=0 rdy=1", rsp_vld_o, reg_req_o, req_rdy_o);
      end
    end
    reg_ack_i = 1'b0;
    run_txn(2'd1, 7'h11, 32'h0, 1, 32'h1357_9BDF, 1'b0, 1, "read_after_reset");
  endtask

  initial begin
    rst         = 1'b1;
    req_vld_i   = 1'b0;
    req_pld_i   = '0;
    rsp_rdy_i   = 1'b0;
    reg_ack_i   = 1'b0;
    reg_rdata_i = '0;
    reg_err_i   = 1'b0;

    test_reset();
    test_read();
    test_write();
    test_nop_rsvd();
    test_timeout();
    test_err_backpressure();
    test_stray_ack();
    test_random();
    test_reset_mid_access();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
